// File: rtl/multiplexed_display_driver.sv
// Scanned seven-segment driver: per-digit blank/PWM slots, leading-zero blanking
// and a double-buffered update that only swaps data at the frame boundary.
//
// Ports:
//   clock, resetN        system clock, async active-low reset
//   data, pointEnable    hex nibble / decimal point per digit (digit k = data[4k+:4])
//   update, busy         capture request; busy while captured data waits for the frame end
//   suppressZeros        blank leading zero digits (digit 0 always shown)
//   brightness           PWM level, on-fraction (brightness+1)/2^BRIGHTNESS_BITS
//   enable               0 = all digits dark, scan keeps running
//   segmentEnableN       active-low {dp,g,f,e,d,c,b,a}
//   digitEnableN         active-low one-cold digit select
//   frameStart           one-clock pulse aligned with slot 0 of digit 0 on the pins
module multiplexed_display_driver #(
    parameter int DIGITS          = 8,
    parameter int REFRESH_DIVISOR = 12500,
    parameter int BLANK_CYCLES    = 16,
    parameter int BRIGHTNESS_BITS = 4
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic [4*DIGITS-1:0]        data,
    input  logic [DIGITS-1:0]          pointEnable,
    input  logic                       update,
    output logic                       busy,
    input  logic                       suppressZeros,
    input  logic [BRIGHTNESS_BITS-1:0] brightness,
    input  logic                       enable,
    output logic [7:0]                 segmentEnableN,
    output logic [DIGITS-1:0]          digitEnableN,
    output logic                       frameStart
);

    localparam int CW   = $clog2(REFRESH_DIVISOR);
    localparam int DW   = $clog2(DIGITS);
    localparam int SPAN = REFRESH_DIVISOR - BLANK_CYCLES;

    typedef enum logic [1:0] {
        PH_BLANK,
        PH_ON,
        PH_OFF
    } phase_e;

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [DW-1:0]              dig_q, dig_d;
    logic [BRIGHTNESS_BITS-1:0] bri_q, bri_d;
    logic [4*DIGITS-1:0]        pend_data_q, pend_data_d;
    logic [DIGITS-1:0]          pend_pe_q, pend_pe_d;
    logic [4*DIGITS-1:0]        act_data_q, act_data_d;
    logic [DIGITS-1:0]          act_pe_q, act_pe_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 seg_q, seg_d;
    logic [DIGITS-1:0]          dign_q, dign_d;
    logic                       fs_q, fs_d;

    logic                       slot_end;
    logic                       frame_end;
    logic [BRIGHTNESS_BITS-1:0] bri_cur;
    logic [31:0]                on_w;
    logic [31:0]                cnt32;
    phase_e                     phase;
    logic [DIGITS-1:0]          supp;
    logic                       zero_above;
    logic [3:0]                 nib;
    logic                       dp;
    logic                       sup;
    logic                       lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h7F;
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_q       <= '0;
            dig_q       <= '0;
            bri_q       <= '0;
            pend_data_q <= '0;
            pend_pe_q   <= '0;
            act_data_q  <= '0;
            act_pe_q    <= '0;
            busy_q      <= 1'b0;
            seg_q       <= 8'hFF;
            dign_q      <= '1;
            fs_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            bri_q       <= bri_d;
            pend_data_q <= pend_data_d;
            pend_pe_q   <= pend_pe_d;
            act_data_q  <= act_data_d;
            act_pe_q    <= act_pe_d;
            busy_q      <= busy_d;
            seg_q       <= seg_d;
            dign_q      <= dign_d;
            fs_q        <= fs_d;
        end
    end

    // Scan counters, slot brightness and the update handshake
    always_comb begin
        slot_end  = (cnt_q == CW'(REFRESH_DIVISOR - 1));
        frame_end = slot_end && (dig_q == DW'(DIGITS - 1));
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        dig_d     = dig_q;
        if (slot_end) begin
            dig_d = frame_end ? '0 : dig_q + DW'(1);
        end
        // Brightness is taken live at c==0 so a blank-free slot still sees it
        bri_cur = (cnt_q == '0) ? brightness : bri_q;
        bri_d   = bri_cur;

        pend_data_d = pend_data_q;
        pend_pe_d   = pend_pe_q;
        act_data_d  = act_data_q;
        act_pe_d    = act_pe_q;
        busy_d      = busy_q;
        if (frame_end && busy_q) begin
            act_data_d = pend_data_q;
            act_pe_d   = pend_pe_q;
            busy_d     = 1'b0;
        end
        if (update && !busy_q) begin
            pend_data_d = data;
            pend_pe_d   = pointEnable;
            busy_d      = 1'b1;
        end
    end

    // Slot phase decode from the slot count
    always_comb begin
        cnt32 = 32'(cnt_q);
        on_w  = (32'(SPAN) * (32'(bri_cur) + 32'd1)) >> BRIGHTNESS_BITS;
        if (cnt32 < 32'(BLANK_CYCLES)) begin
            phase = PH_BLANK;
        end else if (cnt32 < 32'(BLANK_CYCLES) + on_w) begin
            phase = PH_ON;
        end else begin
            phase = PH_OFF;
        end
    end

    // Leading zeros: scan from the MS digit while every nibble seen is zero
    always_comb begin
        supp       = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (act_data_q[4*k +: 4] == 4'h0);
            supp[k]    = suppressZeros && zero_above && (k != 0);
        end
    end

    // Pin values, registered one clock behind the counters
    always_comb begin
        nib = 4'h0;
        dp  = 1'b0;
        sup = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q == DW'(k)) begin
                nib = act_data_q[4*k +: 4];
                dp  = act_pe_q[k];
                sup = supp[k];
            end
        end
        lit   = enable && (phase == PH_ON);
        seg_d = 8'hFF;
        if (lit) begin
            seg_d = {~dp, sup ? 7'h7F : hex7(nib)};
        end
        for (int k = 0; k < DIGITS; k++) begin
            dign_d[k] = !(lit && (dig_q == DW'(k)));
        end
        fs_d = (cnt_q == '0) && (dig_q == '0);
    end

    assign busy           = busy_q;
    assign segmentEnableN = seg_q;
    assign digitEnableN   = dign_q;
    assign frameStart     = fs_q;

endmodule

// File: tb/tb_multiplexed_display_driver.sv
// Bench for multiplexed_display_driver: frame-position reference model checked every
// clock, plus directed literal checks of blanking, PWM, zero suppression and handshake.
module tb_multiplexed_display_driver;

    localparam int ND  = 4;
    localparam int RD  = 20;
    localparam int BL  = 2;
    localparam int BB  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  pe;
    logic        update;
    logic        busy;
    logic        sz;
    logic [1:0]  bri;
    logic        en;
    logic [7:0]  seg;
    logic [3:0]  dign;
    logic        fs;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    multiplexed_display_driver #(
        .DIGITS(ND),
        .REFRESH_DIVISOR(RD),
        .BLANK_CYCLES(BL),
        .BRIGHTNESS_BITS(BB)
    ) dut (
        .clock(clk),
        .resetN(rst_n),
        .data(data),
        .pointEnable(pe),
        .update(update),
        .busy(busy),
        .suppressZeros(sz),
        .brightness(bri),
        .enable(en),
        .segmentEnableN(seg),
        .digitEnableN(dign),
        .frameStart(fs)
    );

    always #5 clk = ~clk;

    logic [7:0] hex_tbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Reference model: position = edges since reset
    int         m_n;
    int         m_bri;
    int         m_pc;
    int         m_pd;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_pe, m_pend_pe;
    logic        m_busy;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fs;

    always @(posedge clk or negedge rst_n) begin : model
        int c, d, b, w;
        logic on, s;
        logic [3:0] nb;
        logic [7:0] v;
        if (!rst_n) begin
            m_n       <= 0;
            m_bri     <= 0;
            m_pc      <= -1;
            m_pd      <= -1;
            m_act     <= '0;
            m_pend    <= '0;
            m_act_pe  <= '0;
            m_pend_pe <= '0;
            m_busy    <= 1'b0;
            e_seg     <= 8'hFF;
            e_dig     <= 4'hF;
            e_fs      <= 1'b0;
        end else begin
            c = m_n % RD;
            d = (m_n / RD) % ND;
            b = (c == 0) ? int'(bri) : m_bri;
            w = ((RD - BL) * (b + 1)) / (1 << BB);
            on = en && (c >= BL) && (c < BL + w);
            nb = m_act[4*d +: 4];
            s  = sz && (d != 0) && ((m_act >> (4 * d)) == 16'h0);
            v  = s ? 8'hFF : hex_tbl[nb];
            if (m_act_pe[d]) v = v & 8'h7F;
            e_seg <= on ? v : 8'hFF;
            e_dig <= on ? ~(4'b0001 << d) : 4'hF;
            e_fs  <= (c == 0) && (d == 0);
            m_bri <= b;
            if ((c == RD - 1) && (d == ND - 1) && m_busy) begin
                m_act    <= m_pend;
                m_act_pe <= m_pend_pe;
                m_busy   <= 1'b0;
            end
            if (update && !m_busy) begin
                m_pend    <= data;
                m_pend_pe <= pe;
                m_busy    <= 1'b1;
            end
            m_pc <= c;
            m_pd <= d;
            m_n  <= m_n + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", nm);
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("pins", {seg, dign, fs, busy}, {e_seg, e_dig, e_fs, m_busy});
        end
    end

    task automatic wait_pin(input int d, input int c);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_pd == d && m_pc == c) break;
        end
        if (k == 400) timeout("wait_pin");
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!m_busy) break;
        end
        if (k == 400) timeout("wait_idle");
    endtask

    task automatic wait_fs(output logic ok);
        int k;
        ok = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_fs");
    endtask

    task automatic count_on(input logic [3:0] pat, output int cnt);
        logic ok;
        cnt = 0;
        wait_fs(ok);
        for (int k = 0; k < RD * ND; k++) begin
            if (k != 0) @(negedge clk);
            if (dign == pat) cnt++;
        end
    endtask

    task automatic period(output int p);
        logic ok;
        p = 0;
        wait_fs(ok);
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (fs) begin
                p = k;
                break;
            end
        end
    endtask

    task automatic pulse_update(input logic [15:0] v, input logic [3:0] p);
        data   = v;
        pe     = p;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic rand_run(input int n);
        logic [31:0] t;
        int z;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            update = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                t = $urandom;
                z = $urandom_range(0, 4);
                for (int j = 0; j < z; j++) t[4*(3-j) +: 4] = 4'h0;
                data = t[15:0];
                pe   = 4'($urandom);
            end
            if ($urandom_range(0, 29) == 0) bri = 2'($urandom);
            if ($urandom_range(0, 39) == 0) en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 59) == 0) sz = ~sz;
        end
        update = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n  = 1'b0;
        data   = '0;
        pe     = '0;
        update = 1'b0;
        sz     = 1'b0;
        bri    = 2'd3;
        en     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 8'hFF);
        check("rst_dig", dign, 4'hF);
        check("rst_fs", fs, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        pulse_update(16'h0000, 4'h0);
        wait_idle();
        count_on(4'hE, cnt);
        check("on_b3", cnt, 18);
        wait_pin(0, 5);
        check("d0_seg", seg, 8'hC0);
        check("d0_dig", dign, 4'hE);

        bri = 2'd0;
        count_on(4'hE, cnt);
        check("on_b0", cnt, 4);
        wait_pin(0, 1);
        check("blank1", dign, 4'hF);
        wait_pin(0, 2);
        check("first_on", dign, 4'hE);
        wait_pin(0, 6);
        check("pwm_off", dign, 4'hF);
        period(cnt);
        check("fs_period", cnt, 80);

        bri = 2'd3;
        sz  = 1'b1;
        pulse_update(16'h0050, 4'b1000);
        wait_idle();
        wait_pin(3, 5);
        check("sup_d3", {seg, dign}, {8'h7F, 4'h7});
        wait_pin(2, 5);
        check("sup_d2", {seg, dign}, {8'hFF, 4'hB});
        wait_pin(1, 5);
        check("sup_d1", {seg, dign}, {8'h92, 4'hD});
        wait_pin(0, 5);
        check("sup_d0", {seg, dign}, {8'hC0, 4'hE});

        sz = 1'b0;
        data = 16'h1234;
        pe = 4'h0;
        update = 1'b1;
        @(negedge clk);
        data = 16'h5678;
        @(negedge clk);
        update = 1'b0;
        check("busy_held", busy, 1'b1);
        wait_idle();
        wait_pin(0, 5);
        check("first_kept", seg, 8'h99);

        wait_pin(0, 5);
        check("pre_dis", dign, 4'hE);
        en = 1'b0;
        @(negedge clk);
        check("dis_seg", seg, 8'hFF);
        check("dis_dig", dign, 4'hF);
        period(cnt);
        check("dis_period", cnt, 80);
        en = 1'b1;

        rand_run(2500);

        en  = 1'b1;
        bri = 2'd3;
        sz  = 1'b0;
        wait_idle();
        pulse_update(16'hFFFF, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", seg, 8'hFF);
        check("mid_rst_dig", dign, 4'hF);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_fs", fs, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_pin(1, 5);
        wait_pin(0, 5);
        check("discarded", seg, 8'hC0);

        rand_run(400);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
